// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit.
//   step_t  : instruction step counter values T0..T5
//   OP_*    : instruction opcodes (IR[9:6])
//   ALU_*   : ALU operation encodings driven on aluop
//   REG_PC  : register index of the program counter (R7)
// Configuration macro: PROC_CTRL_SLT_EN adds the slt opcode and ALU encoding.
package proc_pkg;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_t;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_MVNZ = 4'b0110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

`ifdef PROC_CTRL_SLT_EN
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [2:0] ALU_SLT = 3'b010;
`endif

    localparam logic [2:0] REG_PC  = 3'd7;

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable, used to form register bus selects
// and register load enables.
//   i_sel    : register index 0..7
//   i_en     : when low the output is all zeros
//   o_onehot : one-hot select, bit i_sel set when enabled
module dec3to8 (
    input  logic [2:0] i_sel,
    input  logic       i_en,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Control unit for a simple multi-cycle processor. A 3-bit step counter
// (T0..T5) sequences fetch (T0..T2) and execute (T3..T5); all control
// outputs are combinational from the step, IR, Run and G_nz.
//   Clock, Resetn      : clock, synchronous active-low reset
//   Run                : allows a new fetch while in T0
//   IR[9:0]            : {opcode[3:0], X[2:0], Y[2:0]}
//   G_nz               : datapath register G is nonzero (for mvnz)
//   Rout, Rin          : one-hot bus select / load enable, bit 7 = PC
//   Gout .. Done       : single-bit datapath controls
//   aluop              : 000 add, 001 sub, 010 slt
//   counter            : current step for display
// Configuration macro: PROC_CTRL_SLT_EN enables opcode 0111 (slt).
import proc_pkg::*;

module proc_control (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [9:0] IR,
    input  logic       G_nz,
    output logic [7:0] Rout,
    output logic [7:0] Rin,
    output logic       Gout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       IRin,
    output logic       ADDRin,
    output logic       DOUTin,
    output logic       W_D,
    output logic       incr_pc,
    output logic       Done,
    output logic [2:0] aluop,
    output logic [2:0] counter
);

    step_t      r_step;
    step_t      w_next;

    logic [3:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;

    logic       w_rout_en;
    logic [2:0] w_rout_idx;
    logic       w_rin_en;
    logic [2:0] w_rin_idx;

    assign w_op    = IR[9:6];
    assign w_x     = IR[5:3];
    assign w_y     = IR[2:0];
    assign counter = r_step;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_step <= T0;
        end else begin
            r_step <= w_next;
        end
    end

    // Next step: any Done cycle returns to T0, T0 waits for Run.
    always_comb begin
        w_next = T0;
        if (!Done) begin
            case (r_step)
                T0:      w_next = Run ? T1 : T0;
                T1:      w_next = T2;
                T2:      w_next = T3;
                T3:      w_next = T4;
                T4:      w_next = T5;
                default: w_next = T0;
            endcase
        end
    end

    // Control decode. Register selects are expressed as (enable, index)
    // pairs so each of Rout/Rin is one-hot by construction.
    always_comb begin
        w_rout_en  = 1'b0;
        w_rout_idx = '0;
        w_rin_en   = 1'b0;
        w_rin_idx  = '0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        IRin       = 1'b0;
        ADDRin     = 1'b0;
        DOUTin     = 1'b0;
        W_D        = 1'b0;
        incr_pc    = 1'b0;
        Done       = 1'b0;
        aluop      = ALU_ADD;

        if (Resetn) begin
            case (r_step)
                T0: begin
                    if (Run) begin
                        w_rout_en  = 1'b1;
                        w_rout_idx = REG_PC;
                        ADDRin     = 1'b1;
                        incr_pc    = 1'b1;
                    end
                end
                T1: begin
                    // memory read latency: no controls
                end
                T2: begin
                    IRin = 1'b1;
                end
                T3: begin
                    case (w_op)
                        OP_MV: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_y;
                            w_rin_en   = 1'b1;
                            w_rin_idx  = w_x;
                            Done       = 1'b1;
                        end
                        OP_MVI: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = REG_PC;
                            ADDRin     = 1'b1;
                            incr_pc    = 1'b1;
                        end
`ifdef PROC_CTRL_SLT_EN
                        OP_ADD, OP_SUB, OP_SLT: begin
`else
                        OP_ADD, OP_SUB: begin
`endif
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_x;
                            Ain        = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_y;
                            ADDRin     = 1'b1;
                        end
                        OP_MVNZ: begin
                            w_rout_en  = G_nz;
                            w_rout_idx = w_y;
                            w_rin_en   = G_nz;
                            w_rin_idx  = w_x;
                            Done       = 1'b1;
                        end
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T4: begin
                    case (w_op)
                        OP_ADD: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_y;
                            Gin        = 1'b1;
                            aluop      = ALU_ADD;
                        end
                        OP_SUB: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_y;
                            Gin        = 1'b1;
                            aluop      = ALU_SUB;
                        end
`ifdef PROC_CTRL_SLT_EN
                        OP_SLT: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_y;
                            Gin        = 1'b1;
                            aluop      = ALU_SLT;
                        end
`endif
                        OP_ST: begin
                            w_rout_en  = 1'b1;
                            w_rout_idx = w_x;
                            DOUTin     = 1'b1;
                        end
                        default: begin
                            // mvi/ld wait for memory data
                        end
                    endcase
                end
                T5: begin
                    case (w_op)
                        OP_MVI, OP_LD: begin
                            DINout    = 1'b1;
                            w_rin_en  = 1'b1;
                            w_rin_idx = w_x;
                            Done      = 1'b1;
                        end
`ifdef PROC_CTRL_SLT_EN
                        OP_ADD, OP_SUB, OP_SLT: begin
`else
                        OP_ADD, OP_SUB: begin
`endif
                            Gout      = 1'b1;
                            w_rin_en  = 1'b1;
                            w_rin_idx = w_x;
                            Done      = 1'b1;
                        end
                        OP_ST: begin
                            W_D  = 1'b1;
                            Done = 1'b1;
                        end
                        default: begin
                            // unreachable for single-step opcodes; end the
                            // instruction rather than stall
                            Done = 1'b1;
                        end
                    endcase
                end
                default: begin
                    // encodings 6/7 are never entered; next step is T0
                end
            endcase
        end
    end

    dec3to8 u_dec_rout (
        .i_sel    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    dec3to8 u_dec_rin (
        .i_sel    (w_rin_idx),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [9:0] IR;
    logic       G_nz;
    logic [7:0] Rout;
    logic [7:0] Rin;
    logic       Gout, DINout, Ain, Gin, IRin, ADDRin, DOUTin, W_D, incr_pc, Done;
    logic [2:0] aluop;
    logic [2:0] counter;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    proc_control dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Run     (Run),
        .IR      (IR),
        .G_nz    (G_nz),
        .Rout    (Rout),
        .Rin     (Rin),
        .Gout    (Gout),
        .DINout  (DINout),
        .Ain     (Ain),
        .Gin     (Gin),
        .IRin    (IRin),
        .ADDRin  (ADDRin),
        .DOUTin  (DOUTin),
        .W_D     (W_D),
        .incr_pc (incr_pc),
        .Done    (Done),
        .aluop   (aluop),
        .counter (counter)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // flag vector bit positions: {Gout,DINout,Ain,Gin,IRin,ADDRin,DOUTin,W_D,incr_pc,Done}
    localparam logic [9:0] F_GOUT = 10'h200;
    localparam logic [9:0] F_DIN  = 10'h100;
    localparam logic [9:0] F_AIN  = 10'h080;
    localparam logic [9:0] F_GIN  = 10'h040;
    localparam logic [9:0] F_IRIN = 10'h020;
    localparam logic [9:0] F_ADDR = 10'h010;
    localparam logic [9:0] F_DOUT = 10'h008;
    localparam logic [9:0] F_WD   = 10'h004;
    localparam logic [9:0] F_INC  = 10'h002;
    localparam logic [9:0] F_DONE = 10'h001;

    localparam logic [9:0] I_MVI   = 10'b0001_011_000;
    localparam logic [9:0] I_ADD   = 10'b0010_001_010;
    localparam logic [9:0] I_SUB   = 10'b0011_100_111;
    localparam logic [9:0] I_ST    = 10'b0101_000_101;
    localparam logic [9:0] I_MVNZ  = 10'b0110_111_100;
    localparam logic [9:0] I_MV    = 10'b0000_010_111;
    localparam logic [9:0] I_LD    = 10'b0100_111_001;
    localparam logic [9:0] I_NOP8  = 10'b1000_001_010;
    localparam logic [9:0] I_NOPF  = 10'b1111_111_111;
    localparam logic [9:0] I_SLT   = 10'b0111_011_101;

    typedef struct {
        logic       rn;
        logic       run;
        logic [9:0] ir;
        logic       gnz;
        logic [2:0] cnt;
        logic [7:0] rout;
        logic [7:0] rin;
        logic [9:0] flags;
        logic [2:0] alu;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rn, input logic run, input logic [9:0] ir, input logic gnz,
                     input logic [2:0] cnt, input logic [7:0] ro, input logic [7:0] ri,
                     input logic [9:0] fl, input logic [2:0] al);
        vec_t t;
        t.rn = rn; t.run = run; t.ir = ir; t.gnz = gnz; t.cnt = cnt;
        t.rout = ro; t.rin = ri; t.flags = fl; t.alu = al;
        vecs.push_back(t);
    endtask

    task automatic fetch(input logic [9:0] ir, input logic gnz);
        v(1'b1, 1'b1, ir, gnz, 3'd0, 8'h80, 8'h00, F_ADDR | F_INC, 3'b000);
        v(1'b1, 1'b0, ir, gnz, 3'd1, 8'h00, 8'h00, 10'h000,        3'b000);
        v(1'b1, 1'b0, ir, gnz, 3'd2, 8'h00, 8'h00, F_IRIN,         3'b000);
    endtask

    task automatic idle();
        v(1'b1, 1'b0, 10'h000, 1'b0, 3'd0, 8'h00, 8'h00, 10'h000, 3'b000);
    endtask

    task automatic chk(input string name, input int idx, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [9:0] flags_now();
        return {Gout, DINout, Ain, Gin, IRin, ADDRin, DOUTin, W_D, incr_pc, Done};
    endfunction

    initial begin
        int unsigned cyc;
        bit          seen;

        // reset and idle
        v(1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 8'h00, 8'h00, 10'h000, 3'b000);
        v(1'b0, 1'b1, I_ADD,   1'b1, 3'd0, 8'h00, 8'h00, 10'h000, 3'b000);
        // mvi R3
        fetch(I_MVI, 1'b0);
        v(1'b1, 1'b0, I_MVI, 1'b0, 3'd3, 8'h80, 8'h00, F_ADDR | F_INC, 3'b000);
        v(1'b1, 1'b0, I_MVI, 1'b0, 3'd4, 8'h00, 8'h00, 10'h000,        3'b000);
        v(1'b1, 1'b0, I_MVI, 1'b0, 3'd5, 8'h00, 8'h08, F_DIN | F_DONE, 3'b000);
        idle();
        // add R1,R2
        fetch(I_ADD, 1'b0);
        v(1'b1, 1'b0, I_ADD, 1'b0, 3'd3, 8'h02, 8'h00, F_AIN,           3'b000);
        v(1'b1, 1'b0, I_ADD, 1'b0, 3'd4, 8'h04, 8'h00, F_GIN,           3'b000);
        v(1'b1, 1'b0, I_ADD, 1'b0, 3'd5, 8'h00, 8'h02, F_GOUT | F_DONE, 3'b000);
        idle();
        // sub R4,R7
        fetch(I_SUB, 1'b0);
        v(1'b1, 1'b0, I_SUB, 1'b0, 3'd3, 8'h10, 8'h00, F_AIN,           3'b000);
        v(1'b1, 1'b0, I_SUB, 1'b0, 3'd4, 8'h80, 8'h00, F_GIN,           3'b001);
        v(1'b1, 1'b0, I_SUB, 1'b0, 3'd5, 8'h00, 8'h10, F_GOUT | F_DONE, 3'b000);
        idle();
        // st R0,[R5]
        fetch(I_ST, 1'b0);
        v(1'b1, 1'b0, I_ST, 1'b0, 3'd3, 8'h20, 8'h00, F_ADDR,        3'b000);
        v(1'b1, 1'b0, I_ST, 1'b0, 3'd4, 8'h01, 8'h00, F_DOUT,        3'b000);
        v(1'b1, 1'b0, I_ST, 1'b0, 3'd5, 8'h00, 8'h00, F_WD | F_DONE, 3'b000);
        idle();
        // mvnz PC,R4 with G_nz=0 then 1
        fetch(I_MVNZ, 1'b0);
        v(1'b1, 1'b0, I_MVNZ, 1'b0, 3'd3, 8'h00, 8'h00, F_DONE, 3'b000);
        idle();
        fetch(I_MVNZ, 1'b1);
        v(1'b1, 1'b0, I_MVNZ, 1'b1, 3'd3, 8'h10, 8'h80, F_DONE, 3'b000);
        idle();
        // mv R2,PC
        fetch(I_MV, 1'b0);
        v(1'b1, 1'b0, I_MV, 1'b0, 3'd3, 8'h80, 8'h04, F_DONE, 3'b000);
        idle();
        // ld PC,[R1]
        fetch(I_LD, 1'b0);
        v(1'b1, 1'b0, I_LD, 1'b0, 3'd3, 8'h02, 8'h00, F_ADDR,          3'b000);
        v(1'b1, 1'b0, I_LD, 1'b0, 3'd4, 8'h00, 8'h00, 10'h000,         3'b000);
        v(1'b1, 1'b0, I_LD, 1'b0, 3'd5, 8'h00, 8'h80, F_DIN | F_DONE,  3'b000);
        idle();
        // undefined opcodes
        fetch(I_NOP8, 1'b1);
        v(1'b1, 1'b0, I_NOP8, 1'b1, 3'd3, 8'h00, 8'h00, F_DONE, 3'b000);
        idle();
        fetch(I_NOPF, 1'b1);
        v(1'b1, 1'b0, I_NOPF, 1'b1, 3'd3, 8'h00, 8'h00, F_DONE, 3'b000);
        idle();
        // opcode 0111
        fetch(I_SLT, 1'b0);
`ifdef PROC_CTRL_SLT_EN
        v(1'b1, 1'b0, I_SLT, 1'b0, 3'd3, 8'h08, 8'h00, F_AIN,           3'b000);
        v(1'b1, 1'b0, I_SLT, 1'b0, 3'd4, 8'h20, 8'h00, F_GIN,           3'b010);
        v(1'b1, 1'b0, I_SLT, 1'b0, 3'd5, 8'h00, 8'h08, F_GOUT | F_DONE, 3'b000);
`else
        v(1'b1, 1'b0, I_SLT, 1'b0, 3'd3, 8'h00, 8'h00, F_DONE, 3'b000);
`endif
        idle();
        // Run=0 held in T0 for 5 cycles
        for (int i = 0; i < 5; i++) begin
            v(1'b1, 1'b0, I_MVI, 1'b1, 3'd0, 8'h00, 8'h00, 10'h000, 3'b000);
        end
        // reset during T4 of add
        fetch(I_ADD, 1'b0);
        v(1'b1, 1'b0, I_ADD, 1'b0, 3'd3, 8'h02, 8'h00, F_AIN,   3'b000);
        v(1'b0, 1'b0, I_ADD, 1'b0, 3'd4, 8'h00, 8'h00, 10'h000, 3'b000);
        v(1'b1, 1'b0, I_ADD, 1'b0, 3'd0, 8'h00, 8'h00, 10'h000, 3'b000);

        Resetn = 1'b0;
        Run    = 1'b0;
        IR     = '0;
        G_nz   = 1'b0;
        repeat (2) @(posedge Clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            Resetn = vecs[i].rn;
            Run    = vecs[i].run;
            IR     = vecs[i].ir;
            G_nz   = vecs[i].gnz;
            #1;
            chk("counter", i, {7'd0, counter}, {7'd0, vecs[i].cnt});
            chk("Rout",    i, {2'd0, Rout},    {2'd0, vecs[i].rout});
            chk("Rin",     i, {2'd0, Rin},     {2'd0, vecs[i].rin});
            chk("flags",   i, flags_now(),     vecs[i].flags);
            chk("aluop",   i, {7'd0, aluop},   {7'd0, vecs[i].alu});
        end

        // Run a full mvi and wait, with a cycle bound, for Done: must land
        // five cycles after T0, then return to T0.
        @(negedge Clock);
        Resetn = 1'b1;
        Run    = 1'b1;
        IR     = I_MVI;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 10) begin
            #1;
            if (Done) begin
                seen = 1'b1;
            end else begin
                @(negedge Clock);
                Run = 1'b0;
                cyc++;
            end
        end
        chk("mvi_done_seen",  -1, {9'd0, seen}, 10'd1);
        chk("mvi_done_cycle", -1, cyc[9:0],     10'd5);
        @(negedge Clock);
        #1;
        chk("mvi_return_T0",  -1, {7'd0, counter}, 10'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
